std_latency_buffer: RTL and testbench

//  Sits directly downstream of a fixed-latency std_delay pipeline and converts its output into a

---
 rtl/std_latency_buffer_pkg.sv | 13 +
 rtl/std_latency_buffer_mem.sv | 27 ++
 rtl/std_latency_buffer.sv | 86 ++++++++
 tb/tb_std_latency_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/std_latency_buffer_pkg.sv
// Shared sizing helpers for the latency buffer: counter and pointer widths derived from DEPTH.
package std_latency_buffer_pkg;

    // Counters must represent every value from 0 to depth inclusive.
    function automatic int calc_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int calc_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/std_latency_buffer_mem.sv
// Payload storage: DEPTH x TYPE register array, one synchronous write port, asynchronous read port.
module std_latency_buffer_mem
    import std_latency_buffer_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter int  ADDR_W = calc_ptr_width(DEPTH),
    parameter type TYPE   = logic
)(
    input  logic              i_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  TYPE               wdata,
    input  logic [ADDR_W-1:0] raddr,
    output TYPE               rdata
);

    TYPE mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/std_latency_buffer.sv
// Credit-managed FIFO that turns the output of a fixed-latency pipeline into a valid/ready stream.
module std_latency_buffer
    import std_latency_buffer_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 1,
    parameter type TYPE  = logic [WIDTH-1:0]
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_issue,
    output logic o_can_issue,
    input  logic i_valid,
    input  TYPE  i_d,
    output logic o_valid,
    output TYPE  o_d,
    input  logic i_ready
);

    localparam int CNT_W = calc_cnt_width(DEPTH);
    localparam int PTR_W = calc_ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [CNT_W-1:0] credit;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] in_flight;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             take;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_C) ? '0 : ptr + 1'b1;
    endfunction

    // Outputs come straight from registers: no path from i_valid/i_d or i_ready.
    assign o_can_issue = (credit != '0);
    assign o_valid     = (count != '0);
    assign take        = i_issue && o_can_issue;
    assign push        = i_valid;
    assign pop         = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            credit    <= DEPTH_C;
            count     <= '0;
            in_flight <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            credit    <= credit - CNT_W'(take) + CNT_W'(pop);
            count     <= count + CNT_W'(push) - CNT_W'(pop);
            in_flight <= in_flight + CNT_W'(take) - CNT_W'(push);
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
        end
    end

    std_latency_buffer_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W),
        .TYPE   (TYPE)
    ) u_mem (
        .i_clk (i_clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (i_d),
        .raddr (rd_ptr),
        .rdata (o_d)
    );

    // Every credit is either available, parked in the FIFO, or travelling through the delay line.
    a_issue_with_credit: assert property (@(posedge i_clk) disable iff (!i_rst)
        i_issue |-> (credit != '0));
    a_push_has_room: assert property (@(posedge i_clk) disable iff (!i_rst)
        push |-> ((count < DEPTH_C) || pop));
    a_credit_invariant: assert property (@(posedge i_clk) disable iff (!i_rst)
        (int'(credit) + int'(count) + int'(in_flight)) == DEPTH);

endmodule

// File: tb/tb_std_latency_buffer.sv
// Bench for std_latency_buffer: DEPTH=4 behind a 2-cycle delay line, plus DEPTH=3 wrap checks.
module tb_std_latency_buffer;

    localparam int D4 = 4;
    localparam int D3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DEPTH=4 instance fed by a two-stage delay line
    logic       rst4 = 1'b0, iss4 = 1'b0, rdy4 = 1'b0;
    logic [7:0] id4  = 8'd0;
    logic       val4, can4, ov4;
    logic [7:0] d4, od4;
    logic       dl_v0 = 1'b0, dl_v1 = 1'b0;
    logic [7:0] dl_d0 = 8'd0, dl_d1 = 8'd0;

    always @(posedge clk) begin
        if (!rst4) begin
            dl_v0 <= 1'b0;
            dl_v1 <= 1'b0;
        end else begin
            dl_v0 <= iss4;
            dl_d0 <= id4;
            dl_v1 <= dl_v0;
            dl_d1 <= dl_d0;
        end
    end
    assign val4 = dl_v1;
    assign d4   = dl_d1;

    std_latency_buffer #(.DEPTH(D4), .WIDTH(8)) u_dut4 (
        .i_clk(clk), .i_rst(rst4), .i_issue(iss4), .o_can_issue(can4),
        .i_valid(val4), .i_d(d4), .o_valid(ov4), .o_d(od4), .i_ready(rdy4)
    );

    // DEPTH=3 instance with a zero-latency issuer (issue and push in the same cycle)
    logic       rst3 = 1'b0, put3 = 1'b0, rdy3 = 1'b0;
    logic [7:0] id3  = 8'd0;
    logic       can3, ov3;
    logic [7:0] od3;

    std_latency_buffer #(.DEPTH(D3), .WIDTH(8)) u_dut3 (
        .i_clk(clk), .i_rst(rst3), .i_issue(put3), .o_can_issue(can3),
        .i_valid(put3), .i_d(id3), .o_valid(ov3), .o_d(od3), .i_ready(rdy3)
    );

    // Reference model: FIFO contents and items in flight as plain queues
    logic [7:0] fq4[$];
    logic [7:0] iq4[$];
    logic [7:0] seq4 = 8'd0;
    logic [7:0] fq3[$];
    logic [7:0] out3[$];
    logic [7:0] seq3 = 8'd0;

    function automatic int cred4();
        return D4 - fq4.size() - iq4.size();
    endfunction

    function automatic int cred3();
        return D3 - fq3.size();
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step4(input logic rst, input logic iss, input logic rdy);
        logic       pv;
        logic [7:0] pd;
        rst4 = rst; iss4 = iss; rdy4 = rdy; id4 = seq4;
        pv = val4; pd = d4;
        @(posedge clk);
        if (!rst) begin
            fq4.delete();
            iq4.delete();
        end else begin
            if (fq4.size() != 0 && rdy) void'(fq4.pop_front());
            if (pv) begin
                fq4.push_back(pd);
                if (iq4.size() != 0) void'(iq4.pop_front());
            end
            if (iss) begin
                iq4.push_back(seq4);
                seq4++;
            end
        end
        #1;
        chk("model_can4", int'(can4), int'(cred4() != 0));
        chk("model_valid4", int'(ov4), int'(fq4.size() != 0));
        if (fq4.size() != 0) chk("model_data4", int'(od4), int'(fq4[0]));
    endtask

    task automatic step3(input logic rst, input logic put, input logic rdy);
        rst3 = rst; put3 = put; rdy3 = rdy; id3 = seq3;
        if (rst && ov3 && rdy) out3.push_back(od3);
        @(posedge clk);
        if (!rst) begin
            fq3.delete();
        end else begin
            if (fq3.size() != 0 && rdy) void'(fq3.pop_front());
            if (put) begin
                fq3.push_back(seq3);
                seq3++;
            end
        end
        #1;
        chk("model_can3", int'(can3), int'(cred3() != 0));
        chk("model_valid3", int'(ov3), int'(fq3.size() != 0));
        if (fq3.size() != 0) chk("model_data3", int'(od3), int'(fq3[0]));
    endtask

    typedef struct {
        logic       rst;
        logic       iss;
        logic       rdy;
        logic       can;
        logic       vld;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int         got, first, gaps, drops, seen;
        logic [7:0] base, e;

        // Reset held three cycles, release, then fill under backpressure and drain
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};

        for (int i = 0; i < 15; i++) begin
            step4(tbl[i].rst, tbl[i].iss, tbl[i].rdy);
            chk($sformatf("tbl%0d_can", i), int'(can4), int'(tbl[i].can));
            chk($sformatf("tbl%0d_valid", i), int'(ov4), int'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), int'(od4), int'(tbl[i].d));
        end

        // Full-rate streaming: 20 issues back to back, consumer always ready
        base = seq4; got = 0; first = -1; gaps = 0; drops = 0;
        for (int i = 0; i < 30; i++) begin
            step4(1'b1, (i < 20) && (cred4() != 0), 1'b1);
            if (i < 20 && !can4) drops++;
            if (ov4) begin
                if (first < 0) first = i;
                e = base + got[7:0];
                chk("stream_data", int'(od4), int'(e));
                got++;
            end else if (first >= 0 && got < 20) begin
                gaps++;
            end
        end
        chk("stream_count", got, 20);
        chk("stream_fill", first, 2);
        chk("stream_gaps", gaps, 0);
        chk("stream_can_drops", drops, 0);

        // Full with no credit, then pop and issue together
        for (int i = 0; i < 12; i++) step4(1'b1, cred4() != 0, 1'b0);
        chk("full_can", int'(can4), 0);
        chk("full_valid", int'(ov4), 1);
        step4(1'b1, 1'b0, 1'b1);
        chk("full_pop_can", int'(can4), 1);
        for (int i = 0; i < 12; i++) step4(1'b1, cred4() != 0, 1'b1);

        // Mid-operation reset with three buffered and one in flight
        for (int i = 0; i < 8; i++) step4(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step4(1'b1, 1'b1, 1'b0);
        step4(1'b1, 1'b0, 1'b0);
        chk("mid_pre_valid", int'(ov4), 1);
        chk("mid_pre_can", int'(can4), 0);
        step4(1'b0, 1'b0, 1'b0);
        chk("mid_rst_valid", int'(ov4), 0);
        chk("mid_rst_can", int'(can4), 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step4(1'b1, 1'b0, 1'b1);
            if (ov4) seen++;
        end
        chk("mid_stale", seen, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic r, s, q;
            r = ($urandom_range(0, 99) != 0);
            s = r && ($urandom_range(0, 1) != 0) && (cred4() != 0);
            q = ($urandom_range(0, 3) != 0);
            step4(r, s, q);
        end

        // DEPTH=3: order preserved across pointer wrap
        step3(1'b0, 1'b0, 1'b0);
        step3(1'b0, 1'b0, 1'b0);
        chk("d3_rst_can", int'(can3), 1);
        chk("d3_rst_valid", int'(ov3), 0);
        for (int i = 0; i < 200; i++) begin
            if (seq3 >= 8'd12 && fq3.size() == 0) break;
            step3(1'b1, (seq3 < 8'd12) && ($urandom_range(0, 1) != 0) && (cred3() != 0),
                  $urandom_range(0, 1) != 0);
        end
        chk("d3_count", out3.size(), 12);
        for (int i = 0; i < out3.size(); i++) chk($sformatf("d3_order%0d", i), int'(out3[i]), i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
